pc_sequencer: RTL and testbench

//  Next-PC controller for the fetch stage. It drives the pc_reg write port (pc_next, pc_we)
//  and issues one instruction fetch at a time to the I-cache (req/gnt, then rvalid).
//  It applies branch/jump redirects and traps, holds fetched instructions while decode stalls,
//  and remembers a redirect that arrives while a fetch is outstanding.

---
 rtl/pc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: one outstanding I-cache fetch, redirect/trap handling,
// decode-stall hold buffer. Optional misaligned-target trapping: define PC_SEQ_MISALIGN_CHK_EN.
module pc_sequencer #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'('h100)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc_cur,
    output logic [PC_W-1:0] pc_next,
    output logic            pc_we,
    output logic            fetch_req,
    output logic [PC_W-1:0] fetch_addr,
    input  logic            fetch_gnt,
    input  logic            fetch_rvalid,
    input  logic [31:0]     fetch_inst,
    input  logic            id_stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [PC_W-1:0] trap_pc,
    output logic            inst_valid,
    output logic [31:0]     inst_out,
    output logic [PC_W-1:0] inst_pc,
    output logic            misalign_err
);

    typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          state, state_nx;
    logic            pend_v, pend_trap;
    logic [PC_W-1:0] pend_pc;
    logic [31:0]     hold_inst;
    logic            pend_set, pend_clr, hold_load;

    logic            live_ev, live_bad, use_pend;
    logic [PC_W-1:0] live_raw, live_tgt, ev_tgt, pc_inc;

    assign live_ev  = trap_valid | redirect_valid;
    assign live_raw = trap_valid ? trap_pc : redirect_pc;

`ifdef PC_SEQ_MISALIGN_CHK_EN
    assign live_bad = live_raw[1:0] != 2'b00;
    assign live_tgt = live_bad ? TRAP_VEC : live_raw;
`else
    assign live_bad = 1'b0;
    assign live_tgt = live_raw & ~PC_W'(3);
`endif

    // A pending trap outranks a live redirect; a live trap outranks anything pending.
    assign use_pend = pend_v && (!live_ev || (pend_trap && !trap_valid));
    assign ev_tgt   = use_pend ? pend_pc : live_tgt;
    assign pc_inc   = pc_cur + PC_W'(4);

    assign fetch_addr = pc_cur;
    assign inst_pc    = pc_cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_BOOT;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v    <= 1'b0;
            pend_trap <= 1'b0;
            pend_pc   <= TRAP_VEC;
        end else if (pend_clr) begin
            pend_v    <= 1'b0;
            pend_trap <= 1'b0;
        end else if (pend_set && (trap_valid || !pend_trap)) begin
            pend_v    <= 1'b1;
            pend_trap <= trap_valid;
            pend_pc   <= live_tgt;
        end
    end

    // NOTE: pure data register; validity is carried by the HOLD state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (hold_load) hold_inst <= fetch_inst;
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx     = state;
        pc_next      = pc_cur;
        pc_we        = 1'b0;
        fetch_req    = 1'b0;
        inst_valid   = 1'b0;
        inst_out     = fetch_inst;
        misalign_err = 1'b0;
        pend_set     = 1'b0;
        pend_clr     = 1'b0;
        hold_load    = 1'b0;

        unique case (state)
            S_BOOT: begin
                pc_next  = RESET_VEC;
                pc_we    = 1'b1;
                state_nx = S_REQ;
            end
            S_REQ: begin
                misalign_err = live_ev & live_bad;
                if (live_ev) begin
                    pc_next = live_tgt;
                    pc_we   = 1'b1;
                end else begin
                    fetch_req = 1'b1;
                    if (fetch_gnt) state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                misalign_err = live_ev & live_bad;
                if (fetch_rvalid) begin
                    if (live_ev || pend_v) begin
                        pc_next  = ev_tgt;
                        pc_we    = 1'b1;
                        pend_clr = 1'b1;
                        state_nx = S_REQ;
                    end else if (!id_stall) begin
                        inst_valid = 1'b1;
                        pc_next    = pc_inc;
                        pc_we      = 1'b1;
                        state_nx   = S_REQ;
                    end else begin
                        hold_load = 1'b1;
                        state_nx  = S_HOLD;
                    end
                end else if (live_ev) begin
                    pend_set = 1'b1;
                end
            end
            S_HOLD: begin
                inst_out     = hold_inst;
                misalign_err = live_ev & live_bad;
                if (live_ev) begin
                    pc_next  = live_tgt;
                    pc_we    = 1'b1;
                    state_nx = S_REQ;
                end else begin
                    inst_valid = 1'b1;
                    if (!id_stall) begin
                        pc_next  = pc_inc;
                        pc_we    = 1'b1;
                        state_nx = S_REQ;
                    end
                end
            end
            default: state_nx = S_BOOT;
        endcase

        // Reset silences all strobes immediately, before the state register has settled.
        if (rst) begin
            pc_we        = 1'b0;
            fetch_req    = 1'b0;
            inst_valid   = 1'b0;
            misalign_err = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios, then randomized I-cache latency,
// decode stalls and redirects checked against a transaction-level reference model.
module tb_pc_sequencer;

    localparam int PC_W = 32;

`ifdef PC_SEQ_MISALIGN_CHK_EN
    localparam logic        EXP_ERR = 1'b1;
    localparam logic [31:0] EXP_MIS = 32'h0000_0100;
`else
    localparam logic        EXP_ERR = 1'b0;
    localparam logic [31:0] EXP_MIS = 32'h0000_0040;
`endif

    logic            clk, rst;
    logic [PC_W-1:0] pc_cur, pc_next, fetch_addr, redirect_pc, trap_pc, inst_pc;
    logic            pc_we, fetch_req, fetch_gnt, fetch_rvalid, id_stall;
    logic            redirect_valid, trap_valid, inst_valid, misalign_err;
    logic [31:0]     fetch_inst, inst_out;

    int checks   = 0;
    int failures = 0;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next), .pc_we(pc_we),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_inst(fetch_inst), .id_stall(id_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .inst_valid(inst_valid),
        .inst_out(inst_out), .inst_pc(inst_pc), .misalign_err(misalign_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for pc_reg; its reset value differs from RESET_VEC so the boot write is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        pc_cur <= 32'hDEAD_BEE0;
        else if (pc_we) pc_cur <= pc_next;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the randomized phase
    logic [31:0] exp_addr, grant_addr, tgt;
    logic        in_flight, outstanding, have_resp, killed, trap_locked, ev, exp_iv, idle;
    int          delay, delivered, r;

    initial begin
        rst = 1'b1;
        fetch_gnt = 0; fetch_rvalid = 0; fetch_inst = '0; id_stall = 0;
        redirect_valid = 0; redirect_pc = '0; trap_valid = 0; trap_pc = '0;

        repeat (2) drive_edge();
        @(negedge clk);
        check("rst_pc_we", pc_we, 0);
        check("rst_fetch_req", fetch_req, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_misalign", misalign_err, 0);

        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        check("boot_pc_we", pc_we, 1);
        check("boot_pc_next", pc_next, 32'h0);
        check("boot_fetch_req", fetch_req, 0);

        // Zero-wait sequential fetch from the reset vector
        drive_edge();
        fetch_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("seq_req", fetch_req, 1);
            check("seq_addr", fetch_addr, 32'(4 * k));
            check("seq_req_we", pc_we, 0);
            drive_edge();
            if (k == 2) break;
            fetch_rvalid = 1'b1;
            fetch_inst   = mem_word(32'(4 * k));
            @(negedge clk);
            check("seq_valid", inst_valid, 1);
            check("seq_inst", inst_out, mem_word(32'(4 * k)));
            check("seq_pc", inst_pc, 32'(4 * k));
            check("seq_we", pc_we, 1);
            check("seq_next", pc_next, 32'(4 * k + 4));
            drive_edge();
            fetch_rvalid = 1'b0;
        end

        // Redirect while the fetch at 0x8 is outstanding; response arrives 3 cycles later
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        check("pend_ev_valid", inst_valid, 0);
        check("pend_ev_we", pc_we, 0);
        drive_edge();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) begin
            @(negedge clk);
            check("pend_wait_we", pc_we, 0);
            check("pend_wait_req", fetch_req, 0);
            drive_edge();
        end
        fetch_rvalid = 1'b1;
        fetch_inst   = mem_word(32'h8);
        @(negedge clk);
        check("pend_drop_valid", inst_valid, 0);
        check("pend_drop_we", pc_we, 1);
        check("pend_drop_next", pc_next, 32'h40);
        drive_edge();
        fetch_rvalid = 1'b0;
        @(negedge clk);
        check("pend_addr", fetch_addr, 32'h40);
        check("pend_req", fetch_req, 1);
        drive_edge();

        // Response under decode stall is held, then released
        fetch_rvalid = 1'b1;
        fetch_inst   = mem_word(32'h40);
        id_stall     = 1'b1;
        @(negedge clk);
        check("stall_cap_we", pc_we, 0);
        drive_edge();
        fetch_rvalid = 1'b0;
        fetch_inst   = '0;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", inst_valid, 1);
            check("stall_inst", inst_out, mem_word(32'h40));
            check("stall_pc", inst_pc, 32'h40);
            check("stall_we", pc_we, 0);
            drive_edge();
        end
        id_stall = 1'b0;
        @(negedge clk);
        check("release_valid", inst_valid, 1);
        check("release_inst", inst_out, mem_word(32'h40));
        check("release_we", pc_we, 1);
        check("release_next", pc_next, 32'h44);
        drive_edge();

        // Same-cycle trap and redirect in REQ: trap wins
        trap_valid = 1'b1; trap_pc = 32'h100;
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        @(negedge clk);
        check("prio_req", fetch_req, 0);
        check("prio_we", pc_we, 1);
        check("prio_next", pc_next, 32'h100);
        drive_edge();
        trap_valid = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        check("prio_addr", fetch_addr, 32'h100);
        check("prio_req2", fetch_req, 1);
        drive_edge();

        // Reset while a fetch is outstanding
        rst = 1'b1;
        #1;
        check("midrst_req", fetch_req, 0);
        check("midrst_we", pc_we, 0);
        check("midrst_valid", inst_valid, 0);
        drive_edge();
        rst = 1'b0;
        fetch_gnt = 1'b0;
        @(negedge clk);
        check("reboot_we", pc_we, 1);
        check("reboot_next", pc_next, 32'h0);
        drive_edge();
        @(negedge clk);
        check("reboot_addr", fetch_addr, 32'h0);
        check("reboot_req", fetch_req, 1);
        drive_edge();

        // Misaligned redirect target
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        @(negedge clk);
        check("mis_err", misalign_err, EXP_ERR);
        check("mis_next", pc_next, EXP_MIS);
        drive_edge();
        redirect_valid = 1'b0; redirect_pc = '0;
        @(negedge clk);
        check("mis_err_off", misalign_err, 0);
        check("mis_addr", fetch_addr, EXP_MIS);
        drive_edge();

        // Sequential increment wraps at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        drive_edge();
        redirect_valid = 1'b0; redirect_pc = '0;
        fetch_gnt = 1'b1;
        @(negedge clk);
        check("wrap_addr", fetch_addr, 32'hFFFF_FFFC);
        drive_edge();
        fetch_rvalid = 1'b1;
        fetch_inst   = mem_word(32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_valid", inst_valid, 1);
        check("wrap_next", pc_next, 32'h0);
        drive_edge();
        fetch_rvalid = 1'b0;

        // Randomized phase: DUT is idle in REQ at address 0
        exp_addr = 32'h0; grant_addr = '0;
        in_flight = 0; outstanding = 0; have_resp = 0; killed = 0; trap_locked = 0;
        delay = 0; delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            id_stall  = ($urandom_range(0, 2) == 0);
            fetch_gnt = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 15);
            trap_valid     = (r == 0) || (r == 2);
            redirect_valid = (r == 1) || (r == 2);
            trap_pc        = 32'($urandom_range(0, 255)) << 2;
            redirect_pc    = 32'($urandom_range(0, 255)) << 2;
            if (outstanding && delay == 0) begin
                fetch_rvalid = 1'b1;
                fetch_inst   = mem_word(grant_addr);
            end else begin
                fetch_rvalid = 1'b0;
                fetch_inst   = '0;
                if (outstanding) delay--;
            end

            @(negedge clk);
            ev   = trap_valid | redirect_valid;
            tgt  = trap_valid ? trap_pc : redirect_pc;
            idle = !in_flight;
            check("rnd_req", fetch_req, idle && !ev);
            if (idle && !ev) check("rnd_addr", fetch_addr, exp_addr);
            exp_iv = in_flight && !killed && !ev && (have_resp || (fetch_rvalid && !id_stall));
            check("rnd_valid", inst_valid, exp_iv);
            if (exp_iv) begin
                check("rnd_inst", inst_out, mem_word(grant_addr));
                check("rnd_pc", inst_pc, grant_addr);
            end
            check("rnd_misalign", misalign_err, 0);

            // A redirect only loses to a trap already waiting on the same outstanding fetch.
            if (ev) begin
                if (!(in_flight && !have_resp && trap_locked && !trap_valid)) exp_addr = tgt;
                if (in_flight && !have_resp && trap_valid) trap_locked = 1'b1;
                if (in_flight) killed = 1'b1;
            end
            if (exp_iv && !id_stall) begin
                exp_addr  = grant_addr + 32'd4;
                in_flight = 1'b0;
                have_resp = 1'b0;
                delivered++;
            end
            if (fetch_rvalid) begin
                outstanding = 1'b0;
                if (killed) begin
                    in_flight = 1'b0; killed = 1'b0; trap_locked = 1'b0;
                end else if (in_flight && id_stall) begin
                    have_resp = 1'b1;
                end
            end
            if (have_resp && killed) begin
                in_flight = 1'b0; have_resp = 1'b0; killed = 1'b0;
            end
            if (idle && !ev && fetch_gnt) begin
                in_flight = 1'b1; outstanding = 1'b1; grant_addr = exp_addr;
                delay = $urandom_range(0, 2); killed = 1'b0; trap_locked = 1'b0;
            end
            drive_edge();
        end
        check("rnd_progress", delivered > 200, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
